gpio_div_bridge: RTL

// - Bridge between MicroBlaze MCS GPIO channels (32-bit) and a 64-bit sequential arithmetic core (udiv64 datapath).
// - Assembles 64-bit operands A and B from 32-bit chunks.
// - Launches the core and waits for it to finish, with a watchdog timeout.
// - Latches quotient and remainder, and serves them back as 32-bit chunks with a status word.

---
 rtl/gpio_div_bridge_pkg.sv | 42 ++++
 rtl/gpio_div_bridge_if.sv | 23 ++
 rtl/gpio_div_bridge_ctrl_edge_det.sv | 19 +
 rtl/gpio_div_bridge.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/gpio_div_bridge_pkg.sv
// Shared constants and types for the GPIO-to-divider bridge: chunk indices,
// control/status bit positions and the FSM state encoding.
package gpio_div_pkg;

    localparam int unsigned DEF_CHUNK_W     = 32;
    localparam int unsigned DEF_DATA_W      = 64;
    localparam int unsigned DEF_TIMEOUT_CYC = 256;
    localparam int unsigned DEF_CNT_W       = 16;

    // Write-side chunk indices (in_loc)
    localparam logic [31:0] LOC_A_LO = 32'd0;
    localparam logic [31:0] LOC_A_HI = 32'd1;
    localparam logic [31:0] LOC_B_LO = 32'd2;
    localparam logic [31:0] LOC_B_HI = 32'd3;

    // Read-side chunk indices (out_loc)
    localparam logic [31:0] LOC_Q_LO    = 32'd0;
    localparam logic [31:0] LOC_Q_HI    = 32'd1;
    localparam logic [31:0] LOC_R_LO    = 32'd2;
    localparam logic [31:0] LOC_R_HI    = 32'd3;
    localparam logic [31:0] LOC_RD_A_LO = 32'd4;
    localparam logic [31:0] LOC_RD_B_LO = 32'd5;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_WR    = 1;
    localparam int unsigned CTRL_CLR   = 2;

    localparam int unsigned ST_BUSY    = 0;
    localparam int unsigned ST_DONE    = 1;
    localparam int unsigned ST_DBZ     = 2;
    localparam int unsigned ST_TMO     = 3;
    localparam int unsigned ST_FSM_LSB = 4;
    localparam int unsigned ST_CNT_LSB = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_DONE = 3'd2,
        S_ERR  = 3'd3
    } fsm_t;

endpackage

// File: rtl/gpio_div_bridge_if.sv
// Handshake and operand/result bus between the bridge (master) and the
// sequential divider core (slave).
interface gpio_div_core_if #(
    parameter int unsigned DATA_W = 64
);
    logic [DATA_W-1:0] core_a;
    logic [DATA_W-1:0] core_b;
    logic              core_start;
    logic              core_abort;
    logic              core_done;
    logic [DATA_W-1:0] core_q;
    logic [DATA_W-1:0] core_r;

    modport master (
        output core_a, core_b, core_start, core_abort,
        input  core_done, core_q, core_r
    );

    modport slave (
        input  core_a, core_b, core_start, core_abort,
        output core_done, core_q, core_r
    );
endinterface

// File: rtl/gpio_div_bridge_ctrl_edge_det.sv
// N-bit rising-edge detector: a bit fires for one cycle when it was 0 on the
// previous clock and is 1 now.
module ctrl_edge_det #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] i_sig,
    output logic [N-1:0] o_rise
);
    logic [N-1:0] r_prev;

    always_ff @(posedge clk) begin
        if (reset) r_prev <= '0;
        else       r_prev <= i_sig;
    end

    assign o_rise = i_sig & ~r_prev;
endmodule

// File: rtl/gpio_div_bridge.sv
// GPIO bridge to a 64-bit sequential divider: assembles operands from 32-bit
// chunks, launches the core with a watchdog, and serves results back.
module gpio_div_bridge
    import gpio_div_pkg::*;
#(
    parameter int unsigned CHUNK_W     = DEF_CHUNK_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CHUNK_W-1:0] in_loc,
    input  logic [CHUNK_W-1:0] in_val,
    input  logic [CHUNK_W-1:0] ctrl_reg,
    input  logic [CHUNK_W-1:0] out_loc,
    output logic [CHUNK_W-1:0] out_val,
    output logic [CHUNK_W-1:0] state_reg,
    gpio_div_core_if.master    core
);
    localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    fsm_t               r_state, w_next;
    logic [2:0]         w_rise;
    logic               w_clr, w_start, w_wr;
    logic               w_launch, w_dbz_err, w_finish, w_expire, w_abort, w_wr_en;
    logic [DATA_W-1:0]  r_a, r_b, r_q, r_r;
    logic               r_done, r_dbz, r_tmo;
    logic [WD_W-1:0]    r_wd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_start_p, r_abort_p;
    logic [CHUNK_W-1:0] r_out, w_rd, w_status;
    logic               w_unused;

    ctrl_edge_det #(.N(3)) u_edge (
        .clk    (clk),
        .reset  (reset),
        .i_sig  (ctrl_reg[2:0]),
        .o_rise (w_rise)
    );

    assign w_clr    = w_rise[CTRL_CLR];
    assign w_start  = w_rise[CTRL_START];
    assign w_wr     = w_rise[CTRL_WR];
    assign w_unused = ^ctrl_reg[CHUNK_W-1:3];

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Clear outranks everything; a start consumes the cycle so a coincident write is dropped.
    always_comb begin
        w_next    = r_state;
        w_launch  = 1'b0;
        w_dbz_err = 1'b0;
        w_finish  = 1'b0;
        w_expire  = 1'b0;
        w_abort   = 1'b0;
        w_wr_en   = 1'b0;
        if (w_clr) begin
            w_next  = S_IDLE;
            w_abort = (r_state == S_RUN);
        end else begin
            case (r_state)
                S_RUN: begin
                    if (core.core_done) begin
                        w_finish = 1'b1;
                        w_next   = S_DONE;
                    end else if (r_wd == WD_LAST) begin
                        w_expire = 1'b1;
                        w_abort  = 1'b1;
                        w_next   = S_ERR;
                    end
                end
                default: begin
                    if (w_start) begin
                        if (r_b == '0) begin
                            w_dbz_err = 1'b1;
                            w_next    = S_ERR;
                        end else begin
                            w_launch = 1'b1;
                            w_next   = S_RUN;
                        end
                    end else if (w_wr) begin
                        w_wr_en = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_q       <= '0;
            r_r       <= '0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_tmo     <= 1'b0;
            r_wd      <= '0;
            r_cnt     <= '0;
            r_start_p <= 1'b0;
            r_abort_p <= 1'b0;
            r_out     <= '0;
        end else begin
            r_start_p <= w_launch;
            r_abort_p <= w_abort;
            r_out     <= w_rd;
            if (w_finish) r_cnt <= r_cnt + CNT_W'(1);
            if (w_clr) begin
                r_a    <= '0;
                r_b    <= '0;
                r_q    <= '0;
                r_r    <= '0;
                r_done <= 1'b0;
                r_dbz  <= 1'b0;
                r_tmo  <= 1'b0;
                r_wd   <= '0;
            end else begin
                if (w_launch || w_dbz_err) begin
                    r_done <= 1'b0;
                    r_tmo  <= 1'b0;
                    r_dbz  <= w_dbz_err;
                end
                if (w_launch)              r_wd <= '0;
                else if (r_state == S_RUN) r_wd <= r_wd + WD_W'(1);
                if (w_finish) begin
                    r_q    <= core.core_q;
                    r_r    <= core.core_r;
                    r_done <= 1'b1;
                end
                if (w_expire) r_tmo <= 1'b1;
                if (w_wr_en) begin
                    case (in_loc)
                        LOC_A_LO: r_a[CHUNK_W-1:0]      <= in_val;
                        LOC_A_HI: r_a[DATA_W-1:CHUNK_W] <= in_val;
                        LOC_B_LO: r_b[CHUNK_W-1:0]      <= in_val;
                        LOC_B_HI: r_b[DATA_W-1:CHUNK_W] <= in_val;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        w_rd = '0;
        case (out_loc)
            LOC_Q_LO:    w_rd = r_q[CHUNK_W-1:0];
            LOC_Q_HI:    w_rd = r_q[DATA_W-1:CHUNK_W];
            LOC_R_LO:    w_rd = r_r[CHUNK_W-1:0];
            LOC_R_HI:    w_rd = r_r[DATA_W-1:CHUNK_W];
            LOC_RD_A_LO: w_rd = r_a[CHUNK_W-1:0];
            LOC_RD_B_LO: w_rd = r_b[CHUNK_W-1:0];
            default:     w_rd = '0;
        endcase
    end

    always_comb begin
        w_status                       = '0;
        w_status[ST_BUSY]              = (r_state == S_RUN);
        w_status[ST_DONE]              = r_done;
        w_status[ST_DBZ]               = r_dbz;
        w_status[ST_TMO]               = r_tmo;
        w_status[ST_FSM_LSB +: 3]      = r_state;
        w_status[ST_CNT_LSB +: CNT_W]  = r_cnt;
    end

    assign out_val         = r_out;
    assign state_reg       = w_status;
    assign core.core_a     = r_a;
    assign core.core_b     = r_b;
    assign core.core_start = r_start_p;
    assign core.core_abort = r_abort_p;
endmodule
